bist_controller: RTL
====================

# bist_controller

Sequencing and signature-check stage for the 1-bit full-adder BIST. The block sits downstream of the 4-bit MISR output response analyser and drives the pattern generator enable. On `start` it clears the MISR and runs the TPG for a fixed number of patterns. It then captures the final 4-bit MISR signature, compares it against a golden value, and reports done/pass/fail.

## Interface
- `PATTERN_COUNT`, default 8: number of test patterns applied; legal range 1..255.
- `GOLDEN_SIG`, default 4'b0000: expected fault-free MISR signature; overridden per build.
- `CNT_W`, default 8: width of the pattern counter and `pattern_index`; must hold PATTERN_COUNT-1.

- `clock`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- `start`  in  1  begin a test; sampled only in IDLE and DONE.
- `signature`  in  4  MISR `dataOut` {Q3,Q2,Q1,Q0}.
- `ora_clear`  out  1  registered clear pulse to the MISR reset input.
- `tpg_en`  out  1  pattern generator advance enable; also selects test mode at the CUT mux.
- `pattern_index`  out  CNT_W  index of the pattern currently applied, 0..PATTERN_COUNT-1.
- `busy`  out  1  high in CLEAR, RUN and CAPTURE.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when the captured signature equals GOLDEN_SIG.
- `fail`  out  1  high in DONE when the captured signature differs from GOLDEN_SIG.
- `sig_captured`  out  4  signature latched at end of test.

## Operation
- Moore FSM with states IDLE, CLEAR, RUN, CAPTURE, DONE. All outputs are registers updated on the same edge as the state; nothing is decoded combinationally.
- Reset values: state IDLE; `ora_clear`, `tpg_en`, `busy`, `done`, `pass` and `fail` are 0; `pattern_index` and `sig_captured` are 0.
- IDLE: `start` high → CLEAR.
- CLEAR: lasts exactly 1 cycle, with `ora_clear`=1 and `busy`=1. Next state is RUN.
- RUN:
  - `tpg_en`=1 and `busy`=1.
  - `pattern_index` starts at 0 and increments each cycle.
  - When `pattern_index` = PATTERN_COUNT-1, the next state is CAPTURE. `pattern_index` is then held and does not wrap.
- CAPTURE: lasts 1 cycle, with `tpg_en`=0 and `busy`=1. On the exiting edge:
  - `sig_captured` <= `signature`.
  - `pass` <= (`signature` == GOLDEN_SIG).
  - `fail` <= the inverse of that comparison.
  - The next state is DONE.
- DONE:
  - `done`=1; `pass`, `fail` and `sig_captured` are held indefinitely.
  - `start` high → CLEAR. On that same edge, `done`, `pass` and `fail` clear to 0 and `pattern_index` returns to 0.
- `start` is ignored in CLEAR, RUN and CAPTURE; there is no restart or abort mid-test.
- `pass` and `fail` are never simultaneously 1. Both are 0 outside DONE.
- `start` is level-sampled. If it is held high continuously, a new test begins on the first cycle of DONE.

## Timing
- Let edge E0 be the edge that samples `start`=1 in IDLE or DONE.
- After E0: `ora_clear`=1 for one cycle.
- Edges E1 through E(PATTERN_COUNT): `tpg_en`=1, for exactly PATTERN_COUNT cycles.
- The MISR absorbs the last pattern's response on edge E(PATTERN_COUNT+1), which is also the edge entering CAPTURE.
- `signature` is stable during CAPTURE and is latched on edge E(PATTERN_COUNT+2). `done` rises on that edge.
- Start-to-done latency is PATTERN_COUNT+2 edges; this is 10 with the defaults.
- Reset mid-operation, in any state: outputs drop to reset values asynchronously and the FSM returns to IDLE. A following `start` runs a complete fresh test.
- `ora_clear` is glitch-free because it comes directly from a flop.

## Test plan
- Reset: assert `reset` mid-cycle → all outputs 0 immediately, with no clock edge needed. Release and idle 5 cycles → outputs stay 0.
- Nominal pass (PATTERN_COUNT=8, GOLDEN_SIG=4'hA):
  - Stimulus: pulse `start`; bench drives `signature`=4'hA during CAPTURE.
  - Required: `ora_clear` high 1 cycle; `tpg_en` high exactly 8 cycles with `pattern_index` 0..7.
  - Required: `done`=1 at E10, `pass`=1, `fail`=0, `sig_captured`=4'hA.
- Fail: same run with `signature`=4'h5 in CAPTURE → `done`=1, `pass`=0, `fail`=1, `sig_captured`=4'h5.
- Start during run: extra `start` pulses at `pattern_index`=2 and in CAPTURE → ignored; `tpg_en` still high exactly 8 cycles and `done` still at E10.
- Reset mid-RUN: `reset` asserted at `pattern_index`=3 → IDLE with all outputs 0. After release, `start` → full 8-pattern run completes normally.
- Restart from DONE: after a fail, pulse `start` with `signature`=4'hA → `done` and `fail` drop on E0, `ora_clear` pulses, and the new result is `pass`=1.

Source files
------------

// File: rtl/bist_controller.sv
// bist_controller
//
// Sequencing and signature-check stage of the full-adder BIST. The block is a
// Moore FSM: IDLE -> CLEAR -> RUN -> CAPTURE -> DONE.
// - CLEAR clears the MISR.
// - RUN applies PATTERN_COUNT patterns through the TPG.
// - CAPTURE latches the MISR signature and compares it against GOLDEN_SIG.
// - DONE reports the pass/fail verdict.
//
// Ports
//   clock          rising-edge system clock
//   reset          asynchronous, active-high
//   start          begin a test (sampled in IDLE and DONE only)
//   signature      MISR dataOut {Q3,Q2,Q1,Q0}
//   ora_clear      one-cycle clear pulse to the MISR
//   tpg_en         pattern generator advance / CUT test-mode select
//   pattern_index  index of the pattern currently applied
//   busy           high in CLEAR, RUN, CAPTURE
//   done           high in DONE
//   pass / fail    verdict, valid only while done is high
//   sig_captured   signature latched at end of test
//
// Every output is a flop written on the same edge as the state. The outputs
// therefore carry the values of the state being entered, and no output
// decode follows the state register. ora_clear drives an asynchronous MISR
// clear, so it must be glitch-free.
module bist_controller #(
  parameter int          PATTERN_COUNT = 8,
  parameter logic [3:0]  GOLDEN_SIG    = 4'b0000,
  parameter int          CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       signature,
  output logic             ora_clear,
  output logic             tpg_en,
  output logic [CNT_W-1:0] pattern_index,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [3:0]       sig_captured
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

  state_t state;
  logic   sig_match;

  assign sig_match = (signature == GOLDEN_SIG);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ora_clear     <= 1'b0;
      tpg_en        <= 1'b0;
      pattern_index <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      sig_captured  <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= CLEAR;
            ora_clear     <= 1'b1;
            busy          <= 1'b1;
            pattern_index <= '0;
          end
        end

        // The clear pulse lasts one cycle. The TPG starts on the following
        // edge with index 0.
        CLEAR: begin
          state         <= RUN;
          ora_clear     <= 1'b0;
          tpg_en        <= 1'b1;
          pattern_index <= '0;
        end

        // The index counts 0..PATTERN_COUNT-1 and then holds. It does not
        // wrap, so pattern_index still shows the last pattern applied
        // after the test.
        RUN: begin
          if (pattern_index == LAST_IDX) begin
            state  <= CAPTURE;
            tpg_en <= 1'b0;
          end else begin
            pattern_index <= pattern_index + IDX_ONE;
          end
        end

        // The MISR absorbed the last response on the edge that entered
        // this state. The signature is stable now and is latched on exit.
        CAPTURE: begin
          state        <= DONE;
          busy         <= 1'b0;
          done         <= 1'b1;
          sig_captured <= signature;
          pass         <= sig_match;
          fail         <= ~sig_match;
        end

        // The verdict holds until the next start. A restart drops the
        // verdict on the same edge that raises ora_clear. sig_captured
        // keeps the previous result until the new capture overwrites it.
        DONE: begin
          if (start) begin
            state         <= CLEAR;
            ora_clear     <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            pattern_index <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          ora_clear <= 1'b0;
          tpg_en    <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          pass      <= 1'b0;
          fail      <= 1'b0;
        end
      endcase
    end
  end

endmodule
